// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the execution unit (ALU operations, opcodes, FSM states, instruction fields)
package cpu_pkg;

    typedef enum logic [2:0] {
        Operation_ADD  = 3'd0,
        Operation_SUB  = 3'd1,
        Operation_NOR  = 3'd2,
        Operation_NAND = 3'd3,
        Operation_XOR  = 3'd4,
        Operation_XNOR = 3'd5
    } Operation;

    typedef enum logic [2:0] {
        Opcode_ADD  = 3'd0,
        Opcode_SUB  = 3'd1,
        Opcode_NOR  = 3'd2,
        Opcode_NAND = 3'd3,
        Opcode_XOR  = 3'd4,
        Opcode_XNOR = 3'd5,
        Opcode_LDI  = 3'd6,
        Opcode_NOP  = 3'd7
    } Opcode;

    typedef enum logic [1:0] {
        ExecState_IDLE = 2'd0,
        ExecState_EXEC = 2'd1,
        ExecState_WB   = 2'd2
    } ExecState;

    localparam int INSTR_OPC_LSB = 13;
    localparam int INSTR_RD_LSB  = 11;
    localparam int INSTR_RS_LSB  = 9;
    localparam int INSTR_IMM_LSB = 0;

    function automatic Opcode instrOpcode(input logic [15:0] instr);
        return Opcode'(instr[INSTR_OPC_LSB +: 3]);
    endfunction

    function automatic logic [1:0] instrRd(input logic [15:0] instr);
        return instr[INSTR_RD_LSB +: 2];
    endfunction

    function automatic logic [1:0] instrRs(input logic [15:0] instr);
        return instr[INSTR_RS_LSB +: 2];
    endfunction

    function automatic logic [7:0] instrImm(input logic [15:0] instr);
        return instr[INSTR_IMM_LSB +: 8];
    endfunction

    // ALU opcodes share their encoding with Operation
    function automatic logic isAluOp(input Opcode op);
        return op != Opcode_LDI && op != Opcode_NOP;
    endfunction

    function automatic Operation toOperation(input Opcode op);
        return isAluOp(op) ? Operation'(op) : Operation_ADD;
    endfunction

endpackage

// File: rtl/reg_file.sv
// reg_file: four 8-bit registers, two async read ports, one sync write port, async debug read
module reg_file #(
    parameter logic [7:0] REG_RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] rdAddrA,
    input  logic [1:0] rdAddrB,
    output logic [7:0] rdDataA,
    output logic [7:0] rdDataB,
    input  logic       wrEn,
    input  logic [1:0] wrAddr,
    input  logic [7:0] wrData,
    input  logic [1:0] dbgSel,
    output logic [7:0] dbgData
);

    logic [7:0] regs [4];

    // register storage: reset to REG_RESET_VAL, single write port
    always_ff @(posedge clk or posedge reset)
        if (reset)
            for (int i = 0; i < 4; i++) regs[i] <= REG_RESET_VAL;
        else if (wrEn)
            regs[wrAddr] <= wrData;

    // combinational read ports
    always_comb begin
        rdDataA = regs[rdAddrA];
        rdDataB = regs[rdAddrB];
        dbgData = regs[dbgSel];
    end

endmodule

// File: rtl/exec_unit.sv
// exec_unit: IDLE/EXEC/WB sequencer around an external ALU; macro EXEC_CARRY_CHAIN_EN feeds stored C into ADD/SUB
module exec_unit
    import cpu_pkg::*;
#(
    parameter logic [7:0] REG_RESET_VAL = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] _iInstr,
    input  logic        _iInstrValid,
    output logic        _oInstrReady,
    output logic [7:0]  _oAluA,
    output logic [7:0]  _oAluB,
    output logic        _oAluC,
    output Operation    _oAluOp,
    input  logic [7:0]  _iAluResult,
    input  logic        _iAluFlagCarry,
    input  logic        _iAluFlagZero,
    input  logic        _iAluFlagNeg,
    output logic        _oFlagCarry,
    output logic        _oFlagZero,
    output logic        _oFlagNeg,
    output logic        _oDone,
    input  logic [1:0]  _iDbgSel,
    output logic [7:0]  _oDbgData
);

    ExecState   state;
    Opcode      opcReg;
    logic [1:0] rdReg, rsReg;
    logic [7:0] immReg, rdVal, rsVal, resultReg, wrData;
    logic       resC, resZ, resN, accept, inExec, inWb, wrEn, carryIn;
    logic       unusedInstrBit;

`ifdef EXEC_CARRY_CHAIN_EN
    assign carryIn = (opcReg == Opcode_ADD || opcReg == Opcode_SUB) && _oFlagCarry;
`else
    assign carryIn = 1'b0;
`endif

    // handshake, ALU drive (only in EXEC) and write-back selection
    always_comb begin
        unusedInstrBit = _iInstr[8];
        _oInstrReady   = state == ExecState_IDLE;
        accept         = _iInstrValid && _oInstrReady;
        inExec         = state == ExecState_EXEC;
        inWb           = state == ExecState_WB;
        _oDone         = inWb;
        _oAluA         = inExec ? rdVal : 8'h00;
        _oAluB         = inExec ? rsVal : 8'h00;
        _oAluC         = inExec && carryIn;
        _oAluOp        = inExec ? toOperation(opcReg) : Operation_ADD;
        wrEn           = inWb && opcReg != Opcode_NOP;
        wrData         = opcReg == Opcode_LDI ? immReg : resultReg;
    end

    // sequencer with instruction fields captured on the accepting edge
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state  <= ExecState_IDLE;
            opcReg <= Opcode_NOP;
            rdReg  <= 2'd0;
            rsReg  <= 2'd0;
            immReg <= 8'h00;
        end else begin
            state <= state == ExecState_IDLE ? (accept ? ExecState_EXEC : ExecState_IDLE) :
                     state == ExecState_EXEC ? ExecState_WB : ExecState_IDLE;
            if (accept) begin
                opcReg <= instrOpcode(_iInstr);
                rdReg  <= instrRd(_iInstr);
                rsReg  <= instrRs(_iInstr);
                immReg <= instrImm(_iInstr);
            end
        end

    // ALU result and flags held from the end of EXEC until write-back
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            resultReg <= 8'h00;
            {resC, resZ, resN} <= 3'b000;
        end else if (inExec) begin
            resultReg <= _iAluResult;
            {resC, resZ, resN} <= {_iAluFlagCarry, _iAluFlagZero, _iAluFlagNeg};
        end

    // status flags change only when an ALU op retires
    always_ff @(posedge clk or posedge reset)
        if (reset)
            {_oFlagCarry, _oFlagZero, _oFlagNeg} <= 3'b000;
        else if (inWb && isAluOp(opcReg))
            {_oFlagCarry, _oFlagZero, _oFlagNeg} <= {resC, resZ, resN};

    reg_file #(.REG_RESET_VAL(REG_RESET_VAL)) u_regFile (
        .clk     (clk),
        .reset   (reset),
        .rdAddrA (rdReg),
        .rdAddrB (rsReg),
        .rdDataA (rdVal),
        .rdDataB (rsVal),
        .wrEn    (wrEn),
        .wrAddr  (rdReg),
        .wrData  (wrData),
        .dbgSel  (_iDbgSel),
        .dbgData (_oDbgData)
    );

endmodule
